// File: rtl/muldiv_iter.sv
// muldiv_iter: iterative RV32M multiply/divide execute unit.
//
// A radix-2 engine that retires one multiplier/quotient bit per cycle. Every
// operation takes the same 34 cycles: accept (E0), 32 CALC steps (E1..E32),
// FIX (E33) and DONE, which ends at E34. Only one operation is in flight.
//
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   start       request, accepted only while busy=0
//   funct3      000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//               100 DIV, 101 DIVU, 110 REM, 111 REMU
//   rs1_val     operand A (multiplicand / dividend)
//   rs2_val     operand B (multiplier / divisor)
//   rd_addr     destination register
//   busy        high while an operation is in flight
//   wb_we       one-cycle register file write pulse (never for rd_addr==0)
//   wb_wa       write address, held until the next FIX
//   wb_wd       write data, held until the next FIX
module muldiv_iter #(
    parameter int XLEN = 32,
    parameter int AW   = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [AW-1:0]   rd_addr,
    output logic            busy,
    output logic            wb_we,
    output logic [AW-1:0]   wb_wa,
    output logic [XLEN-1:0] wb_wd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_nxt;

    // Saved operation context
    logic [2:0]      op_f3;
    logic [AW-1:0]   op_rd;
    logic [XLEN-1:0] a_orig;
    logic [XLEN-1:0] b_orig;
    logic            a_neg;      // dividend/multiplicand was negative (signed view)
    logic            res_neg;    // operand signs differ

    // Datapath: acc_hi is the 33-bit partial remainder (divide) or the upper
    // product half (multiply). acc_lo holds the multiplier shifting out
    // (multiply) or the dividend shifting out / quotient shifting in (divide).
    // mcand holds the multiplicand or divisor magnitude.
    logic [XLEN:0]   acc_hi;
    logic [XLEN-1:0] acc_lo;
    logic [XLEN-1:0] mcand;
    logic [4:0]      cnt;

    logic accept;
    assign accept = (state == IDLE) && start;
    assign busy   = (state != IDLE);

    // ---------------------------------------------------------------
    // Operand conditioning at accept
    // ---------------------------------------------------------------
    logic            in_a_signed, in_b_signed;
    logic            in_a_neg, in_b_neg;
    logic [XLEN-1:0] in_a_mag, in_b_mag;

    always_comb begin
        in_a_signed = 1'b0;
        in_b_signed = 1'b0;
        case (funct3)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                in_a_signed = 1'b1;
                in_b_signed = 1'b1;
            end
            3'b010: in_a_signed = 1'b1;
            default: ;
        endcase
        in_a_neg = in_a_signed & rs1_val[XLEN-1];
        in_b_neg = in_b_signed & rs2_val[XLEN-1];
        // Magnitude of 0x80000000 is 0x80000000 as an unsigned value.
        in_a_mag = in_a_neg ? (~rs1_val + 1'b1) : rs1_val;
        in_b_mag = in_b_neg ? (~rs2_val + 1'b1) : rs2_val;
    end

    // ---------------------------------------------------------------
    // One iteration step
    // ---------------------------------------------------------------
    logic            is_div;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   div_shift;
    logic [XLEN+1:0] div_diff;

    assign is_div    = op_f3[2];
    assign mul_sum   = acc_hi + {1'b0, (acc_lo[0] ? mcand : {XLEN{1'b0}})};
    assign div_shift = {acc_hi[XLEN-1:0], acc_lo[XLEN-1]};
    // Top bit set means the trial subtract underflowed: restore.
    assign div_diff  = {1'b0, div_shift} - {2'b00, mcand};

    // ---------------------------------------------------------------
    // Result selection and sign fixup
    // ---------------------------------------------------------------
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0]   quo, rem, fix_res;
    logic              div0;

    always_comb begin
        prod    = {acc_hi[XLEN-1:0], acc_lo};
        prod_s  = res_neg ? (~prod + 1'b1) : prod;
        quo     = acc_lo;
        rem     = acc_hi[XLEN-1:0];
        div0    = (b_orig == '0);
        fix_res = '0;
        case (op_f3)
            3'b000:         fix_res = prod_s[XLEN-1:0];
            3'b001, 3'b010: fix_res = prod_s[2*XLEN-1:XLEN];
            3'b011:         fix_res = prod[2*XLEN-1:XLEN];
            3'b100:         fix_res = div0 ? '1 : (res_neg ? (~quo + 1'b1) : quo);
            3'b101:         fix_res = div0 ? '1 : quo;
            3'b110:         fix_res = div0 ? a_orig : (a_neg ? (~rem + 1'b1) : rem);
            default:        fix_res = div0 ? a_orig : rem;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CALC;
            CALC:    if (cnt == 5'd31) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath and write-back registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            op_f3   <= '0;
            op_rd   <= '0;
            a_orig  <= '0;
            b_orig  <= '0;
            a_neg   <= 1'b0;
            res_neg <= 1'b0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            mcand   <= '0;
            cnt     <= '0;
            wb_we   <= 1'b0;
            wb_wa   <= '0;
            wb_wd   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_f3   <= funct3;
                        op_rd   <= rd_addr;
                        a_orig  <= rs1_val;
                        b_orig  <= rs2_val;
                        a_neg   <= in_a_neg;
                        res_neg <= in_a_neg ^ in_b_neg;
                        acc_hi  <= '0;
                        cnt     <= '0;
                        if (funct3[2]) begin
                            mcand  <= in_b_mag;   // divisor
                            acc_lo <= in_a_mag;   // dividend
                        end else begin
                            mcand  <= in_a_mag;   // multiplicand
                            acc_lo <= in_b_mag;   // multiplier, LSB first
                        end
                    end
                end
                CALC: begin
                    cnt <= cnt + 5'd1;
                    if (is_div) begin
                        acc_hi <= div_diff[XLEN+1] ? div_shift : div_diff[XLEN:0];
                        acc_lo <= {acc_lo[XLEN-2:0], ~div_diff[XLEN+1]};
                    end else begin
                        {acc_hi, acc_lo} <= {1'b0, mul_sum, acc_lo[XLEN-1:1]};
                    end
                end
                FIX: begin
                    wb_wd <= fix_res;
                    wb_wa <= op_rd;
                    wb_we <= (op_rd != '0);
                end
                default: begin
                    wb_we <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// Directed testbench for muldiv_iter: hand-computed vectors, latency/pulse
// accounting per operation, reset and abort behaviour.
module tb_muldiv_iter;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] rs1_val, rs2_val;
    logic [2:0]  rd_addr;
    logic        busy, wb_we;
    logic [2:0]  wb_wa;
    logic [31:0] wb_wd;

    int n_chk  = 0;
    int n_pass = 0;

    muldiv_iter #(.XLEN(32), .AW(3)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .funct3  (funct3),
        .rs1_val (rs1_val),
        .rs2_val (rs2_val),
        .rd_addr (rd_addr),
        .busy    (busy),
        .wb_we   (wb_we),
        .wb_wa   (wb_wa),
        .wb_wd   (wb_wd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Issue one op and follow it for 40 edges after accept. Checks busy
    // length, pulse count, pulse position, write address and data.
    // mid_start pulses start again in the middle of the operation.
    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] rd, input logic [31:0] exp_wd,
                          input bit mid_start);
        int busy_cnt, pulses, we_edge;
        logic [31:0] cap_wd;
        logic [2:0]  cap_wa;
        busy_cnt = 0; pulses = 0; we_edge = -1; cap_wd = '0; cap_wa = '0;
        funct3 = f3; rs1_val = a; rs2_val = b; rd_addr = rd; start = 1'b1;
        @(posedge clk); #1;                       // E0
        start = 1'b0;
        rs1_val = $urandom; rs2_val = $urandom; funct3 = 3'($urandom); rd_addr = 3'($urandom);
        if (busy) busy_cnt++;
        for (int k = 1; k <= 40; k++) begin
            if (mid_start && k == 10) begin
                start = 1'b1; funct3 = 3'b000; rs1_val = 32'd2; rs2_val = 32'd2; rd_addr = 3'd5;
            end
            if (mid_start && k == 12) start = 1'b0;
            @(posedge clk); #1;
            if (busy) busy_cnt++;
            if (wb_we) begin
                pulses++;
                we_edge = k;
                cap_wd = wb_wd;
                cap_wa = wb_wa;
            end
        end
        chk({tag, ".busy_cycles"}, 32'(busy_cnt), 32'd34);
        if (rd == 3'd0) begin
            chk({tag, ".pulses"}, 32'(pulses), 32'd0);
        end else begin
            chk({tag, ".pulses"}, 32'(pulses), 32'd1);
            chk({tag, ".pulse_edge"}, 32'(we_edge), 32'd33);
            chk({tag, ".wa"}, {29'd0, cap_wa}, {29'd0, rd});
            chk({tag, ".wd"}, cap_wd, exp_wd);
            chk({tag, ".wd_hold"}, wb_wd, exp_wd);
        end
    endtask

    initial begin
        int pulses;
        start = 1'b0; funct3 = '0; rs1_val = '0; rs2_val = '0; rd_addr = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.busy", {31'd0, busy}, 32'd0);
        chk("rst.we",   {31'd0, wb_we}, 32'd0);
        chk("rst.wa",   {29'd0, wb_wa}, 32'd0);
        chk("rst.wd",   wb_wd, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("mul_7x6",      3'b000, 32'd7,        32'd6,        3'd3, 32'd42,        1'b0);
        run_op("mul_m3x5",     3'b000, 32'hFFFFFFFD, 32'd5,        3'd1, 32'hFFFFFFF1,  1'b0);
        run_op("mulh_m1xm1",   3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd2, 32'h00000000,  1'b0);
        run_op("mulh_min2",    3'b001, 32'h80000000, 32'h80000000, 3'd4, 32'h40000000,  1'b0);
        run_op("mulhu_ff",     3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 3'd6, 32'hFFFFFFFE,  1'b0);
        run_op("mulhsu_m1x2",  3'b010, 32'hFFFFFFFF, 32'd2,        3'd7, 32'hFFFFFFFF,  1'b0);
        run_op("div_m7_2",     3'b100, 32'hFFFFFFF9, 32'd2,        3'd1, 32'hFFFFFFFD,  1'b0);
        run_op("rem_m7_2",     3'b110, 32'hFFFFFFF9, 32'd2,        3'd2, 32'hFFFFFFFF,  1'b0);
        run_op("div_7_m2",     3'b100, 32'd7,        32'hFFFFFFFE, 3'd3, 32'hFFFFFFFD,  1'b0);
        run_op("rem_7_m2",     3'b110, 32'd7,        32'hFFFFFFFE, 3'd4, 32'd1,         1'b0);
        run_op("divu_ff_10",   3'b101, 32'hFFFFFFFF, 32'h10,       3'd5, 32'h0FFFFFFF,  1'b0);
        run_op("div_ovf",      3'b100, 32'h80000000, 32'hFFFFFFFF, 3'd6, 32'h80000000,  1'b0);
        run_op("rem_ovf",      3'b110, 32'h80000000, 32'hFFFFFFFF, 3'd7, 32'd0,         1'b0);
        run_op("div_5_0",      3'b100, 32'd5,        32'd0,        3'd2, 32'hFFFFFFFF,  1'b1);
        run_op("remu_5_0",     3'b111, 32'd5,        32'd0,        3'd3, 32'd5,         1'b0);
        run_op("rem_m5_0",     3'b110, 32'hFFFFFFFB, 32'd0,        3'd1, 32'hFFFFFFFB,  1'b0);

        // Abort a DIV with reset at cycle 10.
        funct3 = 3'b100; rs1_val = 32'd100; rs2_val = 32'd7; rd_addr = 3'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort.busy_before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("abort.busy", {31'd0, busy}, 32'd0);
        chk("abort.we",   {31'd0, wb_we}, 32'd0);
        chk("abort.wa",   {29'd0, wb_wa}, 32'd0);
        chk("abort.wd",   wb_wd, 32'd0);
        reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (wb_we) pulses++;
        end
        chk("abort.no_pulse", 32'(pulses), 32'd0);

        run_op("mul_rd0", 3'b000, 32'd3, 32'd3, 3'd0, 32'd9, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
